// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 decryption datapath stages.
package ksa_pkg;

   localparam int KEY_BYTES = 3;
   localparam int MEM_DEPTH = 256;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_FILL    = 4'd1,
      ST_READ_I  = 4'd2,
      ST_WAIT_I  = 4'd3,
      ST_CALC_J  = 4'd4,
      ST_READ_J  = 4'd5,
      ST_WAIT_J  = 4'd6,
      ST_WRITE_I = 4'd7,
      ST_WRITE_J = 4'd8,
      ST_DONE    = 4'd9
   } ksa_state_t;

   // Key-byte index that wraps at the last key byte, avoiding a mod-3 divider.
   function automatic logic [1:0] advance_k(input logic [1:0] k, input logic [1:0] last_k);
      logic [1:0] nxt;
      if (k == last_k) begin
         nxt = 2'd0;
      end else begin
         nxt = k + 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// Selects one byte of the 24-bit RC4 key; byte 0 is the most significant byte.
module ksa_key_sel
   import ksa_pkg::*;
(
   input  logic [23:0] key,
   input  logic [1:0]  k,
   output byte_t       key_byte
);

   // Byte mux; the unused index 3 yields zero.
   always_comb begin
      key_byte = 8'h00;
      case (k)
         2'd0:    key_byte = key[23:16];
         2'd1:    key_byte = key[15:8];
         2'd2:    key_byte = key[7:0];
         default: key_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/ksa_swap.sv
// RC4 key-scheduling swap pass over the 256x8 S-RAM.
// Define KSA_INIT_FILL_EN to have the block write S[i] = i itself before swapping.
module ksa_swap #(
   parameter int KEY_BYTES = ksa_pkg::KEY_BYTES,
   parameter int MEM_DEPTH = ksa_pkg::MEM_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] secret_key,
   output logic        busy,
   output logic        done,
   output logic [7:0]  address,
   output logic [7:0]  data,
   output logic        wren,
   input  logic [7:0]  q
);

   import ksa_pkg::*;

   localparam logic [7:0] LAST_I = 8'(MEM_DEPTH - 1);
   localparam logic [1:0] LAST_K = 2'(KEY_BYTES - 1);

   ksa_state_t  state_q, state_d;
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [1:0]  k_q, k_d;
   logic [7:0]  si_q, si_d;
   logic [23:0] key_q, key_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        wren_q, wren_d;
   logic [7:0]  address_q, address_d;
   logic [7:0]  data_q, data_d;
   logic        data_sel_q, data_sel_d;
   byte_t       key_byte_s;

   ksa_key_sel u_key_sel (
      .key      (key_q),
      .k        (k_q),
      .key_byte (key_byte_s)
   );

   // Next-state logic plus next values of the registered RAM-side outputs.
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      si_d       = si_q;
      key_d      = key_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      wren_d     = 1'b0;
      address_d  = 8'h00;
      data_d     = 8'h00;
      data_sel_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d = secret_key;
               i_d   = 8'h00;
               j_d   = 8'h00;
               k_d   = 2'd0;
               si_d  = 8'h00;
`ifdef KSA_INIT_FILL_EN
               state_d = ST_FILL;
`else
               state_d = ST_READ_I;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef KSA_INIT_FILL_EN
         ST_FILL: begin
            if (i_q == LAST_I) begin
               i_d     = 8'h00;
               state_d = ST_READ_I;
            end else begin
               i_d     = i_q + 8'd1;
               state_d = ST_FILL;
            end
         end
`endif
         ST_READ_I: state_d = ST_WAIT_I;
         ST_WAIT_I: state_d = ST_CALC_J;
         ST_CALC_J: begin
            si_d    = q;
            j_d     = j_q + q + key_byte_s;
            state_d = ST_READ_J;
         end
         ST_READ_J:  state_d = ST_WAIT_J;
         ST_WAIT_J:  state_d = ST_WRITE_I;
         ST_WRITE_I: state_d = ST_WRITE_J;
         ST_WRITE_J: begin
            i_d = i_q + 8'd1;
            k_d = advance_k(k_q, LAST_K);
            if (i_q == LAST_I) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ_I;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs follow the state being entered so they are valid from its first cycle.
      case (state_d)
         ST_IDLE: begin
            busy_d = 1'b0;
         end
`ifdef KSA_INIT_FILL_EN
         ST_FILL: begin
            busy_d    = 1'b1;
            wren_d    = 1'b1;
            address_d = i_d;
            data_d    = i_d;
         end
`endif
         ST_READ_I, ST_WAIT_I, ST_CALC_J: begin
            busy_d    = 1'b1;
            address_d = i_d;
         end
         ST_READ_J, ST_WAIT_J: begin
            busy_d    = 1'b1;
            address_d = j_d;
         end
         ST_WRITE_I: begin
            busy_d     = 1'b1;
            wren_d     = 1'b1;
            address_d  = i_d;
            data_sel_d = 1'b1;
         end
         ST_WRITE_J: begin
            busy_d    = 1'b1;
            wren_d    = 1'b1;
            address_d = j_d;
            data_d    = si_d;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         i_q        <= 8'h00;
         j_q        <= 8'h00;
         k_q        <= 2'd0;
         si_q       <= 8'h00;
         key_q      <= 24'h000000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wren_q     <= 1'b0;
         address_q  <= 8'h00;
         data_q     <= 8'h00;
         data_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         si_q       <= si_d;
         key_q      <= key_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wren_q     <= wren_d;
         address_q  <= address_d;
         data_q     <= data_d;
         data_sel_q <= data_sel_d;
      end
   end

   // S[j] only arrives on q during WRITE_I itself, so that write forwards q directly.
   assign data    = data_sel_q ? q : data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign wren    = wren_q;
   assign address = address_q;

endmodule

// File: tb/tb_ksa_swap.sv
// Scoreboard bench for ksa_swap: a reference KSA predicts every RAM write, the done latency and the final RAM.
module tb_ksa_swap;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

`ifdef KSA_INIT_FILL_EN
   localparam int EXP_DONE = 2049;
   localparam int EXP_BUSY = 2048;
   localparam int OFF      = 256;
`else
   localparam int EXP_DONE = 1793;
   localparam int EXP_BUSY = 1792;
   localparam int OFF      = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] secret_key;
   logic        busy;
   logic        done;
   logic [7:0]  address;
   logic [7:0]  data;
   logic        wren;
   logic [7:0]  q;

   logic [7:0]  mem [256];
   logic [7:0]  load_img [256];
   logic [7:0]  exp_mem [256];
   logic        load_req;
   logic [7:0]  addr_r;
   logic [7:0]  q_r;

   wr_t exp_q[$];
   wr_t wr_log[$];

   int cyc = 0;
   int start_cyc = 0;
   int busy_cnt = 0;
   int chk = 0;
   int err = 0;
   bit armed = 1'b0;
   bit done_seen = 1'b0;

   always #5 clk = ~clk;

   ksa_swap dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .busy       (busy),
      .done       (done),
      .address    (address),
      .data       (data),
      .wren       (wren),
      .q          (q)
   );

   // S-RAM with registered address and registered output: q is valid two cycles after the address.
   always @(posedge clk) begin
      if (load_req) begin
         for (int a = 0; a < 256; a++) mem[a] <= load_img[a];
      end else if (wren === 1'b1) begin
         mem[address] <= data;
      end
      addr_r <= address;
      q_r    <= mem[addr_r];
   end
   assign q = q_r;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference RC4 key schedule, expressed as the ordered list of writes a swap pass performs.
   task automatic build_model(input logic [23:0] key);
      int s [256];
      int kb [3];
      int j;
      int t;
      kb[0] = int'(key[23:16]);
      kb[1] = int'(key[15:8]);
      kb[2] = int'(key[7:0]);
      exp_q.delete();
`ifdef KSA_INIT_FILL_EN
      for (int i = 0; i < 256; i++) exp_q.push_back('{a: 8'(i), d: 8'(i)});
`endif
      for (int i = 0; i < 256; i++) s[i] = i;
      j = 0;
      for (int i = 0; i < 256; i++) begin
         j = (j + s[i] + kb[i % 3]) % 256;
         exp_q.push_back('{a: 8'(i), d: 8'(s[j])});
         exp_q.push_back('{a: 8'(j), d: 8'(s[i])});
         t    = s[i];
         s[i] = s[j];
         s[j] = t;
      end
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(s[i]);
   endtask

   // Monitor: compares each RAM write with the scoreboard and times the done pulse.
   initial begin
      wr_t w;
      int  mrel;
      forever begin
         @(posedge clk);
         #2;
         if (wren === 1'b1) begin
            chk++;
            if (exp_q.size() == 0) begin
               err++;
               $display("FAIL unexpected_write: got addr %02h data %02h, required no write", address, data);
            end else begin
               w = exp_q.pop_front();
               if (address !== w.a || data !== w.d) begin
                  err++;
                  $display("FAIL write: got addr %02h data %02h, required addr %02h data %02h", address, data, w.a, w.d);
               end
            end
            wr_log.push_back('{a: address, d: data});
         end
         if (armed) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
               mrel = cyc - start_cyc + 1;
               chk++;
               if (mrel != EXP_DONE) begin
                  err++;
                  $display("FAIL done_latency: got %0d cycles, required %0d", mrel, EXP_DONE);
               end
               chk++;
               if (busy_cnt != EXP_BUSY) begin
                  err++;
                  $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, EXP_BUSY);
               end
               chk++;
               if (busy !== 1'b0) begin
                  err++;
                  $display("FAIL busy_in_done: got %b, required 0", busy);
               end
               done_seen = 1'b1;
               armed     = 1'b0;
            end
         end else if (done === 1'b1) begin
            chk++;
            err++;
            $display("FAIL unexpected_done: got done=1, required 0");
         end
      end
   end

   task automatic load_ram();
      for (int a = 0; a < 256; a++) begin
`ifdef KSA_INIT_FILL_EN
         load_img[a] = 8'($urandom);
`else
         load_img[a] = 8'(a);
`endif
      end
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic issue_start(input logic [23:0] key);
      wr_log.delete();
      busy_cnt  = 0;
      done_seen = 1'b0;
      @(negedge clk);
      secret_key = key;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      armed     = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      secret_key = 24'($urandom);
   endtask

   task automatic run_pass(input logic [23:0] key, input bit spurious);
      int rel;
      int bad;
      build_model(key);
      load_ram();
      issue_start(key);
      for (int c = 0; c < 2600 && !done_seen; c++) begin
         @(negedge clk);
         rel   = cyc - start_cyc + 1;
         start = spurious && (rel == 5 || rel == 100 || rel == 1790);
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      armed = 1'b0;
      chk++;
      if (!done_seen) begin
         err++;
         $display("FAIL done_timeout: got no done, required done at %0d cycles (key %06h)", EXP_DONE, key);
      end
      chk++;
      if (exp_q.size() != 0) begin
         err++;
         $display("FAIL missing_writes: got %0d writes outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         if (mem[a] !== exp_mem[a]) begin
            if (bad == 0) $display("FAIL final_ram: key %06h addr %02h got %02h, required %02h", key, a, mem[a], exp_mem[a]);
            bad++;
         end
      end
      chk++;
      if (bad != 0) err++;
   endtask

   task automatic run_reset(input logic [23:0] key);
      int rel;
      build_model(key);
      load_ram();
      issue_start(key);
      rel = 1;
      for (int c = 0; c < 600 && rel < 500; c++) begin
         @(negedge clk);
         rel = cyc - start_cyc + 1;
      end
      reset = 1'b1;
      armed = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #3;
      chk++;
      if (busy !== 1'b0) begin
         err++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      chk++;
      if (wren !== 1'b0) begin
         err++;
         $display("FAIL reset_wren: got %b, required 0", wren);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic check_log(input int idx, input logic [7:0] a, input logic [7:0] d, input string name);
      chk++;
      if (idx >= wr_log.size()) begin
         err++;
         $display("FAIL %s: got no write #%0d, required addr %02h data %02h", name, idx, a, d);
      end else if (wr_log[idx].a !== a || wr_log[idx].d !== d) begin
         err++;
         $display("FAIL %s: got addr %02h data %02h, required addr %02h data %02h", name, wr_log[idx].a, wr_log[idx].d, a, d);
      end
   endtask

   task automatic check_out(input logic [7:0] got, input logic [7:0] want, input string name);
      chk++;
      if (got !== want) begin
         err++;
         $display("FAIL %s: got %02h, required %02h", name, got, want);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no end of test, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      secret_key = 24'h000000;
      load_req   = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_out({7'h00, busy}, 8'h00, "reset_busy_init");
      check_out({7'h00, done}, 8'h00, "reset_done_init");
      check_out({7'h00, wren}, 8'h00, "reset_wren_init");
      check_out(address, 8'h00, "reset_address_init");
      check_out(data, 8'h00, "reset_data_init");
      @(negedge clk);
      reset = 1'b0;

      run_pass(24'h000000, 1'b0);
      check_log(OFF + 0, 8'h00, 8'h00, "key0_i0_write_i");
      check_log(OFF + 1, 8'h00, 8'h00, "key0_i0_write_j");
      check_log(OFF + 2, 8'h01, 8'h01, "key0_i1_write_i");

      run_pass(24'h000249, 1'b0);
      check_log(OFF + 0, 8'h00, 8'h00, "k249_i0_write_i");
      check_log(OFF + 1, 8'h00, 8'h00, "k249_i0_write_j");
      check_log(OFF + 2, 8'h01, 8'h03, "k249_i1_write_i");
      check_log(OFF + 3, 8'h03, 8'h01, "k249_i1_write_j");

      run_pass(24'($urandom), 1'b1);
      run_reset(24'($urandom));
      run_pass(24'h000249, 1'b0);
      for (int n = 0; n < 2; n++) run_pass(24'($urandom), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule

// File: doc/ksa_swap.md
# ksa_swap

Key-scheduling swap stage of the RC4 decryption datapath. Runs after the S-memory has been filled with S[i] = i, and before the PRGA/decrypt stage. Walks i = 0..255, accumulates j = j + S[i] + key[i mod 3] (mod 256) and swaps S[i] and S[j] in the on-chip 256×8 S-RAM. Owns the RAM port exclusively while busy and hands off via a done pulse.

## Interface
Parameters:
- KEY_BYTES, 3: secret key length in bytes; fixed for this block.
- MEM_DEPTH, 256: S-memory depth; address width is 8.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to run one full KSA pass; sampled only in IDLE.
- secret_key  in  24  key; [23:16] is key byte 0, [7:0] is key byte 2; captured on start acceptance.
- busy  out  1  high from the first cycle after start acceptance until done.
- done  out  1  one-cycle pulse when the pass completes.
- address  out  8  S-RAM address.
- data  out  8  S-RAM write data.
- wren  out  1  S-RAM write enable.
- q  in  8  S-RAM read data; valid two cycles after the address is first driven.

## Operation
- FSM states: IDLE, FILL (only with the macro), READ_I, WAIT_I, CALC_J, READ_J, WAIT_J, WRITE_I, WRITE_J, DONE.
- IDLE: busy=0, wren=0. If start=1, latch secret_key, clear i, j and k (k = i mod 3), then go to READ_I (or to FILL).
- READ_I and WAIT_I: address=i.
- CALC_J: si <= q; j <= j + q + key_byte[k], all mod 256 (8-bit wrap, carries discarded).
- READ_J and WAIT_J: address=j.
- WRITE_I: address=i, data=q (S[j]), wren=1.
- WRITE_J: address=j, data=si, wren=1. Then i++ and k = (k==2 ? 0 : k+1), with no divider. If i was 255, go to DONE; otherwise go to READ_I.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- i==j: WRITE_I and WRITE_J both write the same value. The result is correct and needs no special case.
- start while busy or in DONE: ignored. secret_key changes while busy: ignored.
- wren is high only in WRITE_I, WRITE_J and FILL.

## Timing
- Reset values: busy=0, done=0, wren=0, address=0, data=0. Internal i=0, j=0, k=0, si=0; state=IDLE.
- Reset mid-operation: IDLE on the next edge, and no further writes. RAM contents are left partially swapped; the pass restarts only on a new start.
- Per iteration: exactly 7 cycles (READ_I through WRITE_J).
- Full pass without the macro: start sampled at edge N, so READ_I occupies cycle N+1. The last WRITE_J occupies cycle N+1792, and done is high in cycle N+1793.
- busy is high for exactly 1792 cycles without the macro, and 2048 with it.

## Configuration
- KSA_INIT_FILL_EN defined:
  - After start, the block spends 256 cycles in FILL, writing address=i, data=i, wren=1 for i = 0..255.
  - It then clears i and enters READ_I.
  - done occurs at N+2049.
  - The upstream fill module is then not needed.
- KSA_INIT_FILL_EN undefined: there is no FILL state, and the RAM must already hold S[i] = i before start.

## Structure
- Shared package ksa_pkg holds:
  - state enum ksa_state_t;
  - KEY_BYTES=3 and MEM_DEPTH=256 localparams;
  - typedef byte_t (logic [7:0]) used by all RC4 stages.
- One sub-module, ksa_key_sel: combinational 24-bit key + k[1:0] → key byte (k=3 → 8'h00). It is reused by the PRGA stage.

## Test plan
- Key 24'h000000, RAM pre-filled with identity, start for one cycle. Required:
  - done pulse at exactly 1793 cycles after start;
  - final RAM matches the reference-model KSA dump (model-generated expected array for key 0).
- Key 24'h00_02_49, pre-filled RAM. Required:
  - final RAM equals the golden RC4 KSA output for key {00,02,49};
  - first iteration: j=0x00, so WRITE_I writes S[0]=0x00;
  - second iteration: j=0x03, so WRITE_I writes address 1, data 0x03, and WRITE_J writes address 3, data 0x01.
- i==j case: key 24'h000000 at i=0 (j=0). Required: address 0 is written twice with data 0x00, and no other address is touched in that iteration.
- Start pulses at cycles 5, 100 and 1790 after the first accepted start. Required: all ignored, and exactly one done at 1793.
- reset asserted at cycle 500 of a pass. Required:
  - busy=0 and wren=0 on the next edge, with no further writes;
  - a new start completes with correct output on a re-filled RAM.
- With KSA_INIT_FILL_EN and garbage RAM contents. Required:
  - 256 fill writes, address i with data i;
  - then the same final RAM as in the 24'h00_02_49 case, with done at 2049 cycles.
